// File: rtl/cifra_sbox_rodadas.sv
// ---------------------------------------------------------------------------
// cifra_sbox_rodadas
//   Multi-round nibble substitution cipher core. It encrypts or decrypts a
//   4*NIBBLES-bit word with ROUNDS rounds of key-XOR / S-box / 4-bit rotate
//   and computes one round per clock. A valid/ready handshake is used on the
//   request side and on the result side.
//
//   Encrypt round : x <= rotl4(S(x ^ chave))
//   Decrypt round : x <= Si(rotr4(x)) ^ chave
//
// Ports
//   clk            in   1  clock, rising edge
//   reset_n        in   1  asynchronous reset, active-low
//   entrada_valid  in   1  request valid
//   entrada_ready  out  1  core is IDLE and can accept a request
//   entrada        in   W  plaintext (modo=0) or ciphertext (modo=1)
//   chave          in   W  round key, the same key in every round
//   modo           in   1  0 = encrypt, 1 = decrypt
//   saida          out  W  result word, held until the next completion
//   saida_valid    out  1  result available
//   saida_ready    in   1  consumer accepts the result
//
// States
//   state | meaning
//   IDLE  | waiting for a request, entrada_ready=1
//   BUSY  | running rounds, one per clock
//   DONE  | result on saida, saida_valid=1 until saida_ready
// ---------------------------------------------------------------------------
module cifra_sbox_rodadas #(
    parameter int NIBBLES = 4,
    parameter int ROUNDS  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   entrada_valid,
    output logic                   entrada_ready,
    input  logic [4*NIBBLES-1:0]   entrada,
    input  logic [4*NIBBLES-1:0]   chave,
    input  logic                   modo,
    output logic [4*NIBBLES-1:0]   saida,
    output logic                   saida_valid,
    input  logic                   saida_ready
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_x;
    logic [W-1:0]   r_chave;
    logic [W-1:0]   r_saida;
    logic           r_modo;
    logic [CW-1:0]  r_count;
    logic [W-1:0]   w_round;
    logic           w_accept;
    logic           w_last;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h7;  4'h1: y = 4'hC;  4'h2: y = 4'h5;  4'h3: y = 4'h2;
            4'h4: y = 4'hB;  4'h5: y = 4'h1;  4'h6: y = 4'h9;  4'h7: y = 4'hF;
            4'h8: y = 4'hD;  4'h9: y = 4'h8;  4'hA: y = 4'h0;  4'hB: y = 4'hE;
            4'hC: y = 4'h3;  4'hD: y = 4'hA;  4'hE: y = 4'h6;  default: y = 4'h4;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hA;  4'h1: y = 4'h5;  4'h2: y = 4'h3;  4'h3: y = 4'hC;
            4'h4: y = 4'hF;  4'h5: y = 4'h2;  4'h6: y = 4'hE;  4'h7: y = 4'h0;
            4'h8: y = 4'h9;  4'h9: y = 4'h6;  4'hA: y = 4'hD;  4'hB: y = 4'h4;
            4'hC: y = 4'h1;  4'hD: y = 4'h8;  4'hE: y = 4'hB;  default: y = 4'h7;
        endcase
        return y;
    endfunction

    function automatic logic [W-1:0] sub_word(input logic [W-1:0] x, input logic inv);
        logic [W-1:0] y;
        y = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            y[4*i +: 4] = inv ? sbox_inv(x[4*i +: 4]) : sbox(x[4*i +: 4]);
        end
        return y;
    endfunction

    // Shift-based rotates degenerate to the identity when W == 4.
    function automatic logic [W-1:0] rotl4(input logic [W-1:0] x);
        return (x << 4) | (x >> (W - 4));
    endfunction

    function automatic logic [W-1:0] rotr4(input logic [W-1:0] x);
        return (x >> 4) | (x << (W - 4));
    endfunction

    assign w_round  = r_modo ? (sub_word(rotr4(r_x), 1'b1) ^ r_chave)
                             : rotl4(sub_word(r_x ^ r_chave, 1'b0));
    assign w_accept = (r_state == IDLE) && entrada_valid;
    assign w_last   = (r_state == BUSY) && (r_count == LAST_ROUND);
    assign saida    = r_saida;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        entrada_ready = 1'b0;
        saida_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                entrada_ready = 1'b1;
                if (entrada_valid) begin
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                saida_valid = 1'b1;
                if (saida_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x     <= '0;
            r_chave <= '0;
            r_modo  <= 1'b0;
            r_count <= '0;
            r_saida <= '0;
        end else if (w_accept) begin
            r_x     <= entrada;
            r_chave <= chave;
            r_modo  <= modo;
            r_count <= '0;
        end else if (r_state == BUSY) begin
            r_x     <= w_round;
            r_count <= r_count + CW'(1);
            if (w_last) begin
                r_saida <= w_round;
            end
        end
    end

endmodule
